// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the three-channel TMDS encoder:
// control tokens, symbol width, popcount and bit reversal.
package tmds_pkg;

  localparam int TMDS_W = 10;

  localparam logic [TMDS_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ENC_BALANCED,
    ENC_INVERT,
    ENC_DIRECT
  } enc_case_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [TMDS_W-1:0] ctrl_token(input logic [1:0] c);
    logic [TMDS_W-1:0] t;
    case (c)
      2'b00:   t = CTRL_TOKEN_00;
      2'b01:   t = CTRL_TOKEN_01;
      2'b10:   t = CTRL_TOKEN_10;
      default: t = CTRL_TOKEN_11;
    endcase
    return t;
  endfunction

  function automatic logic [TMDS_W-1:0] bit_reverse(input logic [TMDS_W-1:0] v);
    logic [TMDS_W-1:0] r;
    r = '0;
    for (int i = 0; i < TMDS_W; i++) begin
      r[i] = v[TMDS_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/tmds_encoder_rgb_if.sv
// Pixel-side inputs and TMDS symbol outputs of the RGB encoder, bundled
// so the pixel source and the encoder share one connection.
interface tmds_encoder_rgb_if;
  import tmds_pkg::*;

  logic              de_i;
  logic              hsync_i;
  logic              vsync_i;
  logic [7:0]        pix_r;
  logic [7:0]        pix_g;
  logic [7:0]        pix_b;
  logic [TMDS_W-1:0] tmds_ch0;
  logic [TMDS_W-1:0] tmds_ch1;
  logic [TMDS_W-1:0] tmds_ch2;

  modport master (
    output de_i, hsync_i, vsync_i, pix_r, pix_g, pix_b,
    input  tmds_ch0, tmds_ch1, tmds_ch2
  );

  modport slave (
    input  de_i, hsync_i, vsync_i, pix_r, pix_g, pix_b,
    output tmds_ch0, tmds_ch1, tmds_ch2
  );

endinterface

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: stage 1 builds the transition-minimised q_m word,
// stage 2 applies DC balancing with a running disparity counter.
module tmds_channel_enc
  import tmds_pkg::*;
(
  input  logic              clk_pix,
  input  logic              rst,
  input  logic              de,
  input  logic [1:0]        c,
  input  logic [7:0]        d,
  output logic [TMDS_W-1:0] q
);

  logic [8:0]        qm_d, qm_q;
  logic [3:0]        n1qm_d, n1qm_q;
  logic              de_d, de_q;
  logic [1:0]        c_d, c_q;
  logic [TMDS_W-1:0] q_d, q_q;
  logic signed [4:0] cnt_d, cnt_q;

  logic [3:0]        n1_data;
  logic              use_xnor;
  logic              chain;
  logic signed [4:0] n1_s;
  logic signed [4:0] diff;
  logic signed [4:0] two_qm8;
  logic signed [4:0] two_nqm8;
  enc_case_e         enc_sel;

  always_comb begin
    n1_data  = popcount8(d);
    use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !d[0]);
    qm_d     = '0;
    chain    = d[0];
    qm_d[0]  = chain;
    for (int i = 1; i < 8; i++) begin
      chain   = use_xnor ? ~(chain ^ d[i]) : (chain ^ d[i]);
      qm_d[i] = chain;
    end
    qm_d[8]  = ~use_xnor;
    n1qm_d   = popcount8(qm_d[7:0]);
    de_d     = de;
    c_d      = c;
  end

  // diff is N1-N0 of q_m[7:0], i.e. 2*N1-8, kept in signed 5 bits
  always_comb begin
    n1_s     = $signed({1'b0, n1qm_q});
    diff     = n1_s + n1_s - 5'sd8;
    two_qm8  = qm_q[8] ? 5'sd2 : 5'sd0;
    two_nqm8 = qm_q[8] ? 5'sd0 : 5'sd2;
    enc_sel  = ENC_DIRECT;
    q_d      = ctrl_token(c_q);
    cnt_d    = '0;

    if ((cnt_q == 5'sd0) || (diff == 5'sd0)) begin
      enc_sel = ENC_BALANCED;
    end else if (((cnt_q > 5'sd0) && (diff > 5'sd0)) ||
                 ((cnt_q < 5'sd0) && (diff < 5'sd0))) begin
      enc_sel = ENC_INVERT;
    end

    if (de_q) begin
      case (enc_sel)
        ENC_BALANCED: begin
          q_d   = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
          cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end
        ENC_INVERT: begin
          q_d   = {1'b1, qm_q[8], ~qm_q[7:0]};
          cnt_d = cnt_q + two_qm8 - diff;
        end
        default: begin
          q_d   = {1'b0, qm_q[8], qm_q[7:0]};
          cnt_d = cnt_q + diff - two_nqm8;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      qm_q   <= '0;
      n1qm_q <= '0;
      de_q   <= 1'b0;
      c_q    <= 2'b00;
      q_q    <= CTRL_TOKEN_00;
      cnt_q  <= '0;
    end else begin
      qm_q   <= qm_d;
      n1qm_q <= n1qm_d;
      de_q   <= de_d;
      c_q    <= c_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tmds_encoder_rgb.sv
// Three-channel DVI TMDS encoder; sync travels on the blue channel and
// SWAP_BITS reverses each symbol for MSB-first serializers.
module tmds_encoder_rgb
  import tmds_pkg::*;
#(
  parameter bit SWAP_BITS = 1'b0
)
(
  input  logic               clk_pix,
  input  logic               rst,
  tmds_encoder_rgb_if.slave  bus
);

  logic [TMDS_W-1:0] sym_b;
  logic [TMDS_W-1:0] sym_g;
  logic [TMDS_W-1:0] sym_r;

  tmds_channel_enc u_ch0 (
    .clk_pix (clk_pix),
    .rst     (rst),
    .de      (bus.de_i),
    .c       ({bus.vsync_i, bus.hsync_i}),
    .d       (bus.pix_b),
    .q       (sym_b)
  );

  tmds_channel_enc u_ch1 (
    .clk_pix (clk_pix),
    .rst     (rst),
    .de      (bus.de_i),
    .c       (2'b00),
    .d       (bus.pix_g),
    .q       (sym_g)
  );

  tmds_channel_enc u_ch2 (
    .clk_pix (clk_pix),
    .rst     (rst),
    .de      (bus.de_i),
    .c       (2'b00),
    .d       (bus.pix_r),
    .q       (sym_r)
  );

  assign bus.tmds_ch0 = SWAP_BITS ? bit_reverse(sym_b) : sym_b;
  assign bus.tmds_ch1 = SWAP_BITS ? bit_reverse(sym_g) : sym_g;
  assign bus.tmds_ch2 = SWAP_BITS ? bit_reverse(sym_r) : sym_r;

endmodule

// File: tb/tb_tmds_encoder_rgb.sv
// Bench for tmds_encoder_rgb: two builds (normal and bit-swapped) share the
// same stimulus and are checked every cycle against a DVI reference model.
module tb_tmds_encoder_rgb;

  localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  logic clk_pix;
  logic rst;
  int   checks;
  int   errors;
  bit   chk_en;

  tmds_encoder_rgb_if bus0 ();
  tmds_encoder_rgb_if bus1 ();

  assign bus1.de_i    = bus0.de_i;
  assign bus1.hsync_i = bus0.hsync_i;
  assign bus1.vsync_i = bus0.vsync_i;
  assign bus1.pix_r   = bus0.pix_r;
  assign bus1.pix_g   = bus0.pix_g;
  assign bus1.pix_b   = bus0.pix_b;

  tmds_encoder_rgb #(.SWAP_BITS(1'b0)) dut0 (
    .clk_pix (clk_pix),
    .rst     (rst),
    .bus     (bus0)
  );

  tmds_encoder_rgb #(.SWAP_BITS(1'b1)) dut1 (
    .clk_pix (clk_pix),
    .rst     (rst),
    .bus     (bus1)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  // Reference encoder straight from the DVI rules, using integer counts
  function automatic logic [9:0] model_sym(input logic de, input logic [1:0] c,
                                           input logic [7:0] d, inout int cnt);
    int         ones;
    int         n1;
    int         n0;
    bit         inv;
    logic [7:0] qm;
    logic       qm8;
    logic [9:0] s;
    if (!de) begin
      cnt = 0;
      return TOK[c];
    end
    ones  = $countones(d);
    inv   = (ones > 4) || ((ones == 4) && (d[0] == 1'b0));
    qm    = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = inv ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    end
    qm8 = !inv;
    n1  = $countones(qm);
    n0  = 8 - n1;
    if ((cnt == 0) || (n1 == n0)) begin
      s   = {~qm8, qm8, qm8 ? qm : ~qm};
      cnt = cnt + (qm8 ? (n1 - n0) : (n0 - n1));
    end else if (((cnt > 0) && (n1 > n0)) || ((cnt < 0) && (n0 > n1))) begin
      s   = {1'b1, qm8, ~qm};
      cnt = cnt + 2 * int'(qm8) + n0 - n1;
    end else begin
      s   = {1'b0, qm8, qm};
      cnt = cnt + n1 - n0 - 2 * int'(!qm8);
    end
    return s;
  endfunction

  function automatic logic [9:0] rev10(input logic [9:0] v);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  logic       s1_de;
  logic [1:0] s1_c;
  logic [7:0] s1_d [3];
  logic [9:0] exp_sym [3];
  int         cnt_m [3];
  logic [9:0] nxt_sym [3];
  int         nxt_cnt [3];

  initial begin
    s1_de = 1'b0;
    s1_c  = 2'b00;
    for (int ch = 0; ch < 3; ch++) begin
      s1_d[ch]    = 8'h00;
      exp_sym[ch] = 10'h354;
      cnt_m[ch]   = 0;
    end
  end

  always_comb begin
    int c_tmp;
    c_tmp = 0;
    for (int ch = 0; ch < 3; ch++) begin
      c_tmp        = cnt_m[ch];
      nxt_sym[ch]  = model_sym(s1_de, (ch == 0) ? s1_c : 2'b00, s1_d[ch], c_tmp);
      nxt_cnt[ch]  = c_tmp;
    end
  end

  always @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      s1_de <= 1'b0;
      s1_c  <= 2'b00;
      for (int ch = 0; ch < 3; ch++) begin
        exp_sym[ch] <= 10'h354;
        cnt_m[ch]   <= 0;
      end
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        exp_sym[ch] <= nxt_sym[ch];
        cnt_m[ch]   <= nxt_cnt[ch];
      end
      s1_de   <= bus0.de_i;
      s1_c    <= {bus0.vsync_i, bus0.hsync_i};
      s1_d[0] <= bus0.pix_b;
      s1_d[1] <= bus0.pix_g;
      s1_d[2] <= bus0.pix_r;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic de, input logic hs, input logic vs,
                               input logic [7:0] r, input logic [7:0] g,
                               input logic [7:0] b);
    @(posedge clk_pix);
    #1;
    bus0.de_i    = de;
    bus0.hsync_i = hs;
    bus0.vsync_i = vs;
    bus0.pix_r   = r;
    bus0.pix_g   = g;
    bus0.pix_b   = b;
  endtask

  // Every cycle: both builds against the model, plus internal disparity
  always @(negedge clk_pix) begin
    if (chk_en) begin
      int cv0;
      int cv1;
      int cv2;
      cv0 = int'(dut0.u_ch0.cnt_q);
      cv1 = int'(dut0.u_ch1.cnt_q);
      cv2 = int'(dut0.u_ch2.cnt_q);
      checkOutput("ch0", int'(bus0.tmds_ch0), int'(exp_sym[0]));
      checkOutput("ch1", int'(bus0.tmds_ch1), int'(exp_sym[1]));
      checkOutput("ch2", int'(bus0.tmds_ch2), int'(exp_sym[2]));
      checkOutput("swap_ch0", int'(bus1.tmds_ch0), int'(rev10(exp_sym[0])));
      checkOutput("swap_ch1", int'(bus1.tmds_ch1), int'(rev10(exp_sym[1])));
      checkOutput("swap_ch2", int'(bus1.tmds_ch2), int'(rev10(exp_sym[2])));
      checkOutput("cnt0", cv0, cnt_m[0]);
      checkOutput("cnt1", cv1, cnt_m[1]);
      checkOutput("cnt2", cv2, cnt_m[2]);
      checkOutput("cnt_bound", int'((cv0 >= -8) && (cv0 <= 8) && (cv1 >= -8) &&
                  (cv1 <= 8) && (cv2 >= -8) && (cv2 <= 8)), 1);
    end
  end

  task automatic checkResetTokens(input string tag);
    checkOutput({tag, "_ch0"}, int'(bus0.tmds_ch0), 'h354);
    checkOutput({tag, "_ch1"}, int'(bus0.tmds_ch1), 'h354);
    checkOutput({tag, "_ch2"}, int'(bus0.tmds_ch2), 'h354);
    checkOutput({tag, "_swap_ch0"}, int'(bus1.tmds_ch0), 'h0AB);
    checkOutput({tag, "_swap_ch2"}, int'(bus1.tmds_ch2), 'h0AB);
  endtask

  initial begin
    int   burst;
    logic de_r;
    checks = 0;
    errors = 0;
    chk_en = 1'b1;
    rst    = 1'b0;
    bus0.de_i    = 1'b1;
    bus0.hsync_i = 1'b1;
    bus0.vsync_i = 1'b0;
    bus0.pix_r   = 8'($urandom);
    bus0.pix_g   = 8'($urandom);
    bus0.pix_b   = 8'($urandom);

    #1 rst = 1'b1;
    #2 checkResetTokens("rst_async");

    repeat (2) @(posedge clk_pix);
    #1;
    rst = 1'b0;
    bus0.de_i    = 1'b0;
    bus0.hsync_i = 1'b0;
    bus0.vsync_i = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkResetTokens("rst_idle");

    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    checkOutput("tok01_ch0", int'(bus0.tmds_ch0), 'h0AB);
    checkOutput("tok01_ch1", int'(bus0.tmds_ch1), 'h354);
    checkOutput("tok01_ch2", int'(bus0.tmds_ch2), 'h354);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("tok10_ch0", int'(bus0.tmds_ch0), 'h154);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("tok11_ch0", int'(bus0.tmds_ch0), 'h2AB);
    checkOutput("tok11_ch1", int'(bus0.tmds_ch1), 'h354);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("walk0_ch0", int'(bus0.tmds_ch0), 'h100);
    checkOutput("walk0_cnt0", int'(dut0.u_ch0.cnt_q), -8);
    checkOutput("full_ch1", int'(bus0.tmds_ch1), 'h200);
    checkOutput("full_cnt1", int'(dut0.u_ch1.cnt_q), -8);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("walk1_ch0", int'(bus0.tmds_ch0), 'h3FF);
    checkOutput("walk1_cnt0", int'(dut0.u_ch0.cnt_q), 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("walk2_ch0", int'(bus0.tmds_ch0), 'h100);
    checkOutput("walk2_cnt0", int'(dut0.u_ch0.cnt_q), -6);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    checkOutput("walk3_ch0", int'(bus0.tmds_ch0), 'h354);
    checkOutput("walk3_cnt0", int'(dut0.u_ch0.cnt_q), 0);

    burst = 0;
    de_r  = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (burst == 0) begin
        de_r  = ~de_r;
        burst = de_r ? int'($urandom_range(60, 1)) : int'($urandom_range(12, 1));
      end
      burst--;
      applyStimulus(de_r, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    8'($urandom), 8'($urandom), 8'($urandom));
      if (i == 5000) begin
        #2 rst = 1'b1;
        #1 checkResetTokens("rst_mid");
        @(posedge clk_pix);
        #1 rst = 1'b0;
      end
    end

    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    @(posedge clk_pix);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
